// File: rtl/clause_terminal_unit_if.sv
// Bus bundle for clause_terminal_unit: clause capture inputs and registered result outputs.
// master drives requests (array controller or bench), slave is the evaluator.
interface clause_terminal_unit_if #(
  parameter int NUM_LIT     = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
);
  localparam int IDX_W = (NUM_LIT > 1) ? $clog2(NUM_LIT) : 1;

  logic                         start_i;
  logic [WIDTH_C_LEN-1:0]       clause_len_i;
  logic [NUM_LIT-1:0]           lit_sat_i;
  logic [NUM_LIT-1:0]           lit_false_i;
  logic [NUM_LIT*WIDTH_LVL-1:0] lit_lvl_i;
  logic                         clr_conflict_i;
  logic [31:0]                  debug_cid_i;
  logic                         busy_o;
  logic                         done_o;
  logic                         csat_o;
  logic                         imp_o;
  logic [IDX_W-1:0]             imp_idx_o;
  logic                         conflict_o;
  logic [WIDTH_LVL-1:0]         cmax_lvl_o;

  modport master (
    output start_i, clause_len_i, lit_sat_i, lit_false_i, lit_lvl_i,
           clr_conflict_i, debug_cid_i,
    input  busy_o, done_o, csat_o, imp_o, imp_idx_o, conflict_o, cmax_lvl_o
  );

  modport slave (
    input  start_i, clause_len_i, lit_sat_i, lit_false_i, lit_lvl_i,
           clr_conflict_i, debug_cid_i,
    output busy_o, done_o, csat_o, imp_o, imp_idx_o, conflict_o, cmax_lvl_o
  );
endinterface

// File: rtl/clause_terminal_unit.sv
// Sequential per-clause terminal evaluator: captures a clause, scans one literal per cycle.
// Optional CT_EARLY_EXIT_EN: finish the scan on the first satisfied literal.
module clause_terminal_unit #(
  parameter int NUM_LIT     = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  clause_terminal_unit_if.slave bus
);
  localparam int IDX_W = (NUM_LIT > 1) ? $clog2(NUM_LIT) : 1;
  localparam logic [WIDTH_C_LEN-1:0] LEN_MAX = WIDTH_C_LEN'(NUM_LIT);
  localparam logic [WIDTH_C_LEN-1:0] LEN_ONE = WIDTH_C_LEN'(1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                                r_state, w_state_next;
  logic [WIDTH_C_LEN-1:0]                r_len, w_len_next;
  logic [WIDTH_C_LEN-1:0]                r_idx, w_idx_next;
  logic [NUM_LIT-1:0]                    r_sat_v, w_sat_v_next;
  logic [NUM_LIT-1:0]                    r_false_v, w_false_v_next;
  logic [NUM_LIT-1:0][WIDTH_LVL-1:0]     r_lvl, w_lvl_next, w_lvl_in;
  logic                                  r_sat, w_sat_next;
  logic [1:0]                            r_freecnt, w_freecnt_next;
  logic [WIDTH_LVL-1:0]                  r_maxlvl, w_maxlvl_next;
  logic [IDX_W-1:0]                      r_free_idx, w_free_idx_next;
  logic                                  r_busy, w_busy_next;
  logic                                  r_done, w_done_next;
  logic                                  r_csat, w_csat_next;
  logic                                  r_imp, w_imp_next;
  logic [IDX_W-1:0]                      r_imp_idx, w_imp_idx_next;
  logic                                  r_conflict, w_conflict_next, w_conf_set;
  logic [WIDTH_LVL-1:0]                  r_cmax, w_cmax_next;

  logic [WIDTH_C_LEN-1:0] w_len_clamp;
  logic [IDX_W-1:0]       w_slot;
  logic                   w_cur_sat, w_cur_false, w_cur_free;
  logic [WIDTH_LVL-1:0]   w_cur_lvl;
  logic                   w_sat_acc;
  logic [WIDTH_LVL-1:0]   w_max_acc;
  logic [1:0]             w_free_acc;
  logic [IDX_W-1:0]       w_fidx_acc;
  logic                   w_last, w_exit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LIT; gi++) begin : g_lvl_unpack
      assign w_lvl_in[gi] = bus.lit_lvl_i[gi*WIDTH_LVL +: WIDTH_LVL];
    end
  endgenerate

  assign w_len_clamp = (bus.clause_len_i > LEN_MAX) ? LEN_MAX : bus.clause_len_i;

  // Per-slot classification; a literal flagged both sat and false counts as sat.
  assign w_slot      = r_idx[IDX_W-1:0];
  assign w_cur_sat   = r_sat_v[w_slot];
  assign w_cur_false = r_false_v[w_slot] & ~w_cur_sat;
  assign w_cur_free  = ~r_sat_v[w_slot] & ~r_false_v[w_slot];
  assign w_cur_lvl   = r_lvl[w_slot];

  assign w_sat_acc  = r_sat | w_cur_sat;
  assign w_max_acc  = (w_cur_false && (w_cur_lvl > r_maxlvl)) ? w_cur_lvl : r_maxlvl;
  assign w_free_acc = w_cur_free ? ((r_freecnt == 2'd2) ? 2'd2 : r_freecnt + 2'd1) : r_freecnt;
  assign w_fidx_acc = (w_cur_free && (r_freecnt == 2'd0)) ? w_slot : r_free_idx;
  assign w_last     = (r_idx == r_len - LEN_ONE);

`ifdef CT_EARLY_EXIT_EN
  assign w_exit = w_last | w_cur_sat;
`else
  assign w_exit = w_last;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_len_next      = r_len;
    w_idx_next      = r_idx;
    w_sat_v_next    = r_sat_v;
    w_false_v_next  = r_false_v;
    w_lvl_next      = r_lvl;
    w_sat_next      = r_sat;
    w_freecnt_next  = r_freecnt;
    w_maxlvl_next   = r_maxlvl;
    w_free_idx_next = r_free_idx;
    w_done_next     = 1'b0;
    w_csat_next     = r_csat;
    w_imp_next      = r_imp;
    w_imp_idx_next  = r_imp_idx;
    w_cmax_next     = r_cmax;
    w_conf_set      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_len_next      = w_len_clamp;
          w_sat_v_next    = bus.lit_sat_i;
          w_false_v_next  = bus.lit_false_i;
          w_lvl_next      = w_lvl_in;
          w_sat_next      = 1'b0;
          w_freecnt_next  = 2'd0;
          w_maxlvl_next   = '0;
          w_idx_next      = '0;
          w_free_idx_next = '0;
          if (w_len_clamp == '0) begin
            // Empty clause: results are all zero and never raise a conflict.
            w_state_next   = S_DONE;
            w_done_next    = 1'b1;
            w_csat_next    = 1'b0;
            w_imp_next     = 1'b0;
            w_imp_idx_next = '0;
            w_cmax_next    = '0;
          end else begin
            w_state_next = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        w_sat_next      = w_sat_acc;
        w_freecnt_next  = w_free_acc;
        w_maxlvl_next   = w_max_acc;
        w_free_idx_next = w_fidx_acc;
        w_idx_next      = r_idx + LEN_ONE;
        if (w_exit) begin
          w_state_next   = S_DONE;
          w_done_next    = 1'b1;
          w_csat_next    = w_sat_acc;
          w_imp_next     = !w_sat_acc && (w_free_acc == 2'd1);
          w_imp_idx_next = w_fidx_acc;
          w_cmax_next    = w_sat_acc ? '0 : w_max_acc;
          w_conf_set     = !w_sat_acc && (w_free_acc == 2'd0);
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_busy_next     = (w_state_next != S_IDLE);
    w_conflict_next = w_conf_set | (r_conflict & ~bus.clr_conflict_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_sat_v    <= '0;
      r_false_v  <= '0;
      r_lvl      <= '0;
      r_sat      <= 1'b0;
      r_freecnt  <= 2'd0;
      r_maxlvl   <= '0;
      r_free_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csat     <= 1'b0;
      r_imp      <= 1'b0;
      r_imp_idx  <= '0;
      r_conflict <= 1'b0;
      r_cmax     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_len      <= w_len_next;
      r_idx      <= w_idx_next;
      r_sat_v    <= w_sat_v_next;
      r_false_v  <= w_false_v_next;
      r_lvl      <= w_lvl_next;
      r_sat      <= w_sat_next;
      r_freecnt  <= w_freecnt_next;
      r_maxlvl   <= w_maxlvl_next;
      r_free_idx <= w_free_idx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_csat     <= w_csat_next;
      r_imp      <= w_imp_next;
      r_imp_idx  <= w_imp_idx_next;
      r_conflict <= w_conflict_next;
      r_cmax     <= w_cmax_next;
    end
  end

  // The clause id only matters for simulation traceability of accepted requests.
  a_cid_known: assert property (@(posedge clk)
    (rst && (r_state == S_IDLE) && bus.start_i) |-> !$isunknown(bus.debug_cid_i));

  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.csat_o     = r_csat;
  assign bus.imp_o      = r_imp;
  assign bus.imp_idx_o  = r_imp_idx;
  assign bus.conflict_o = r_conflict;
  assign bus.cmax_lvl_o = r_cmax;
endmodule

// File: tb/tb_clause_terminal_unit.sv
// Bench for clause_terminal_unit: directed test-plan cases plus randomized traffic
// against a latency/result model computed straight from the clause contents.
module tb_clause_terminal_unit;
  localparam int NL = 8;
  localparam int WL = 16;
  localparam int WC = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clause_terminal_unit_if #(.NUM_LIT(NL), .WIDTH_LVL(WL), .WIDTH_C_LEN(WC)) bus ();

  clause_terminal_unit #(.NUM_LIT(NL), .WIDTH_LVL(WL), .WIDTH_C_LEN(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_phase = 0;   // 0 idle, 1 evaluating, 2 result cycle
  int           m_left  = 0;
  bit           m_set;
  bit           exp_busy = 0, exp_done = 0, exp_csat = 0, exp_imp = 0, exp_conf = 0;
  bit [IW-1:0]  exp_idx  = '0;
  bit [WL-1:0]  exp_cmax = '0;
  bit           p_csat, p_imp, p_conf;
  bit [IW-1:0]  p_idx;
  bit [WL-1:0]  p_cmax;
  int           p_lat;

  task automatic eval_clause(input bit [WC-1:0] len, input bit [NL-1:0] s, input bit [NL-1:0] f,
                             input bit [NL*WL-1:0] lv);
    int L, nfree, first_sat;
    bit any_sat;
    bit [WL-1:0] mx, v;
    L = (int'(len) > NL) ? NL : int'(len);
    nfree = 0; first_sat = -1; any_sat = 0; mx = '0; p_idx = '0;
    for (int k = 0; k < L; k++) begin
      v = lv[k*WL +: WL];
      if (s[k]) begin
        any_sat = 1;
        if (first_sat < 0) first_sat = k;
      end else if (f[k]) begin
        if (v > mx) mx = v;
      end else begin
        if (nfree == 0) p_idx = IW'(k);
        nfree++;
      end
    end
    p_csat = any_sat;
    p_imp  = !any_sat && nfree == 1;
    p_cmax = any_sat ? '0 : mx;
    p_conf = !any_sat && nfree == 0 && L != 0;
    if (L == 0) p_lat = 1;
`ifdef CT_EARLY_EXIT_EN
    else if (any_sat) p_lat = first_sat + 2;
`endif
    else p_lat = L + 1;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = 0; exp_busy = 0; exp_done = 0; exp_csat = 0; exp_imp = 0;
      exp_idx = '0; exp_cmax = '0; exp_conf = 0;
    end else begin
      m_set = 0;
      exp_done = 0;
      if (m_phase == 2) begin
        m_phase = 0;
        exp_busy = 0;
      end else if (m_phase == 0 && bus.start_i) begin
        eval_clause(bus.clause_len_i, bus.lit_sat_i, bus.lit_false_i, bus.lit_lvl_i);
        m_phase = 1; m_left = p_lat; exp_busy = 1;
      end
      if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2; exp_done = 1;
          exp_csat = p_csat; exp_imp = p_imp; exp_idx = p_idx; exp_cmax = p_cmax;
          m_set = p_conf;
        end
      end
      exp_conf = m_set | (exp_conf & !bus.clr_conflict_i);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("busy", bus.busy_o, exp_busy);
    chk("done", bus.done_o, exp_done);
    chk("conflict", bus.conflict_o, exp_conf);
    chk("csat", bus.csat_o, exp_csat);
    chk("imp", bus.imp_o, exp_imp);
    chk("cmax", bus.cmax_lvl_o, exp_cmax);
    if (exp_imp) chk("imp_idx", bus.imp_idx_o, exp_idx);
  end

  // ---------------- stimulus ----------------
  function automatic bit [NL*WL-1:0] lv8(input int a, b, c, d, e, f, g, h);
    bit [NL*WL-1:0] r;
    r = {WL'(h), WL'(g), WL'(f), WL'(e), WL'(d), WL'(c), WL'(b), WL'(a)};
    return r;
  endfunction

  task automatic junk_inputs();
    bus.clause_len_i = WC'($urandom);
    bus.lit_sat_i    = NL'($urandom);
    bus.lit_false_i  = NL'($urandom);
    bus.lit_lvl_i    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_dir(input string name, input bit [WC-1:0] len, input bit [NL-1:0] s,
                         input bit [NL-1:0] f, input bit [NL*WL-1:0] lv, input int e_lat,
                         input bit e_csat, input bit e_imp, input bit [IW-1:0] e_idx,
                         input bit [WL-1:0] e_cmax, input bit e_conf, input bit hold_clr,
                         input bit poke);
    int n, g;
    g = 0;
    while (bus.busy_o !== 1'b0 && g < 50) begin @(negedge clk); g++; end
    bus.start_i = 1'b1; bus.clause_len_i = len; bus.lit_sat_i = s; bus.lit_false_i = f;
    bus.lit_lvl_i = lv; bus.clr_conflict_i = hold_clr; bus.debug_cid_i++;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done_o === 1'b1) break;
      bus.start_i = poke && (n == 1);
      junk_inputs();
    end
    bus.start_i = 1'b0;
    bus.clr_conflict_i = 1'b0;
    $display("%s: latency=%0d csat=%0d imp=%0d idx=%0d cmax=%0d conflict=%0d", name, n,
             bus.csat_o, bus.imp_o, bus.imp_idx_o, bus.cmax_lvl_o, bus.conflict_o);
    chk({name, "_latency"}, n, e_lat);
    chk({name, "_csat"}, bus.csat_o, e_csat);
    chk({name, "_imp"}, bus.imp_o, e_imp);
    if (e_imp) chk({name, "_imp_idx"}, bus.imp_idx_o, e_idx);
    chk({name, "_cmax"}, bus.cmax_lvl_o, e_cmax);
    chk({name, "_conflict"}, bus.conflict_o, e_conf);
    @(negedge clk);
    chk({name, "_conflict_hold"}, bus.conflict_o, e_conf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.start_i = 0; bus.clause_len_i = 0; bus.lit_sat_i = 0; bus.lit_false_i = 0;
    bus.lit_lvl_i = 0; bus.clr_conflict_i = 0; bus.debug_cid_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_csat", bus.csat_o, 0);
    chk("rst_imp", bus.imp_o, 0);
    chk("rst_imp_idx", bus.imp_idx_o, 0);
    chk("rst_conflict", bus.conflict_o, 0);
    chk("rst_cmax", bus.cmax_lvl_o, 0);
    rst = 1'b1;
    @(negedge clk);

    run_dir("all_false", 3, 8'h00, 8'hFF, lv8(5, 9, 2, 0, 0, 0, 0, 0), 4, 0, 0, 0, 9, 1, 0, 0);
    run_dir("two_free_sticky", 3, 8'h00, 8'h04, lv8(0, 0, 4, 0, 0, 0, 0, 0), 4, 0, 0, 0, 4, 1, 0, 0);
    bus.clr_conflict_i = 1'b1;
    @(negedge clk);
    bus.clr_conflict_i = 1'b0;
    chk("clr_conflict", bus.conflict_o, 0);
    run_dir("unit_poke", 4, 8'h00, 8'h0B, lv8(1, 7, 0, 3, 0, 0, 0, 0), 5, 0, 1, 2, 7, 0, 0, 1);
    run_dir("len_zero", 0, 8'hFF, 8'hFF, lv8(9, 9, 9, 9, 9, 9, 9, 9), 1, 0, 0, 0, 0, 0, 0, 0);
    run_dir("clr_vs_set", 2, 8'h00, 8'h03, lv8(100, 200, 0, 0, 0, 0, 0, 0), 3, 0, 0, 0, 200, 1, 1, 0);
    run_dir("clamp_unsigned", 12, 8'h00, 8'hFF, lv8(1, 4, 7, 10, 13, 16'hFFFF, 19, 22),
            9, 0, 0, 0, 16'hFFFF, 1, 0, 0);
`ifdef CT_EARLY_EXIT_EN
    run_dir("sat_slot1", 4, 8'h02, 8'h00, lv8(3, 3, 3, 3, 0, 0, 0, 0), 3, 1, 0, 0, 0, 1, 0, 0);
    run_dir("sat_and_false", 2, 8'h01, 8'h03, lv8(50, 60, 0, 0, 0, 0, 0, 0), 2, 1, 0, 0, 0, 1, 0, 0);
`else
    run_dir("sat_slot1", 4, 8'h02, 8'h00, lv8(3, 3, 3, 3, 0, 0, 0, 0), 5, 1, 0, 0, 0, 1, 0, 0);
    run_dir("sat_and_false", 2, 8'h01, 8'h03, lv8(50, 60, 0, 0, 0, 0, 0, 0), 3, 1, 0, 0, 0, 1, 0, 0);
`endif

    // Reset in the middle of an L=6 scan.
    bus.start_i = 1'b1; bus.clause_len_i = 6; bus.lit_sat_i = 0; bus.lit_false_i = 0;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("mid_scan_reset: busy=%0d csat=%0d conflict=%0d", bus.busy_o, bus.csat_o, bus.conflict_o);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_done", bus.done_o, 0);
    chk("abort_csat", bus.csat_o, 0);
    chk("abort_conflict", bus.conflict_o, 0);
    chk("abort_cmax", bus.cmax_lvl_o, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Randomized traffic; the per-cycle compare checks every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.start_i        = ($urandom_range(0, 2) == 0);
      bus.clause_len_i   = WC'($urandom_range(0, 15));
      bus.lit_sat_i      = NL'($urandom & $urandom & $urandom);
      bus.lit_false_i    = NL'($urandom | $urandom);
      if ($urandom_range(0, 1) == 0)
        bus.lit_lvl_i = {$urandom, $urandom, $urandom, $urandom};
      else
        bus.lit_lvl_i = {$urandom, $urandom, $urandom, $urandom} & {NL{16'h000F}};
      bus.clr_conflict_i = ($urandom_range(0, 9) == 0);
      bus.debug_cid_i    = 32'(c);
      rst                = ($urandom_range(0, 299) != 0);
      if (bus.start_i && rst)
        $display("rand start cid=%0d len=%0d sat=%h false=%h", c, bus.clause_len_i,
                 bus.lit_sat_i, bus.lit_false_i);
      @(negedge clk);
    end
    rst = 1'b1;
    bus.start_i = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
